// File: rtl/mat_vec_ctrl_if.sv
`default_nettype none
//============================================================================
// Module   : mat_vec_ctrl_if
// Brief    : Memory read/write port and multiplier-side bundle of mat_vec_ctrl.
// Revision : 1.0
//============================================================================
interface mat_vec_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
);
    logic                      mem_rd_req;
    logic [ADDR_WIDTH-1:0]     mem_rd_addr;
    logic                      mem_rd_valid;
    logic [8*DATA_WIDTH-1:0]   mem_rd_data;
    logic                      mem_wr_req;
    logic [ADDR_WIDTH-1:0]     mem_wr_addr;
    logic [3*DATA_WIDTH-1:0]   mem_wr_data;
    logic                      mem_wr_ack;
    logic                      mv_clr;
    logic                      mv_a_wren;
    logic [DATA_WIDTH-1:0]     mv_a_data [8];
    logic                      mv_b_wren;
    logic [DATA_WIDTH-1:0]     mv_b_data;
    logic                      mv_done;
    logic [3*DATA_WIDTH-1:0]   mv_out [8];

    modport master (
        output mem_rd_req, mem_rd_addr,
        input  mem_rd_valid, mem_rd_data,
        output mem_wr_req, mem_wr_addr, mem_wr_data,
        input  mem_wr_ack,
        output mv_clr, mv_a_wren, mv_a_data, mv_b_wren, mv_b_data,
        input  mv_done, mv_out
    );

    modport slave (
        input  mem_rd_req, mem_rd_addr,
        output mem_rd_valid, mem_rd_data,
        input  mem_wr_req, mem_wr_addr, mem_wr_data,
        output mem_wr_ack,
        input  mv_clr, mv_a_wren, mv_a_data, mv_b_wren, mv_b_data,
        output mv_done, mv_out
    );
endinterface
`default_nettype wire

// File: rtl/mat_vec_ctrl.sv
`default_nettype none
//============================================================================
// Module   : mat_vec_ctrl
// Brief    : Job sequencer for one 8x8 matrix-vector multiplier instance.
// Revision : 1.0
//============================================================================
module mat_vec_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 1024
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  start,
    input  wire logic [ADDR_WIDTH-1:0] src_addr,
    input  wire logic [ADDR_WIDTH-1:0] dst_addr,
    output logic                       busy,
    output logic                       finished,
    output logic                       error,
    mat_vec_ctrl_if.master             bus
);
    localparam int c_RES_W = 3 * DATA_WIDTH;
    localparam int c_TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_CLEAR     = 3'd1;
    localparam logic [2:0] c_FETCH_A   = 3'd2;
    localparam logic [2:0] c_FETCH_B   = 3'd3;
    localparam logic [2:0] c_PUSH_B    = 3'd4;
    localparam logic [2:0] c_WAIT_DONE = 3'd5;
    localparam logic [2:0] c_WRITEBACK = 3'd6;
    localparam logic [2:0] c_FINISH    = 3'd7;

    logic [2:0]            r_state;
    logic [2:0]            w_next;
    logic [ADDR_WIDTH-1:0] r_src;
    logic [ADDR_WIDTH-1:0] r_dst;
    logic [2:0]            r_cnt;       // column, vector element or result index
    logic [DATA_WIDTH-1:0] r_bvec [8];
    logic [c_RES_W-1:0]    r_res  [8];
    logic [c_TMO_W-1:0]    r_tmo;
    logic                  r_done_q;
    logic                  r_error;

    logic                  w_done_edge;
    logic                  w_last;
    logic                  w_rd_req;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic                  w_a_load;
    logic                  w_b_wren;
    logic [DATA_WIDTH-1:0] w_b_data;
    logic                  w_wr_req;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [c_RES_W-1:0]    w_wr_data;

    // A done level left high by the previous job must not complete this one.
    assign w_done_edge = bus.mv_done & ~r_done_q;
    assign w_last      = (r_cnt == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:      if (start) w_next = c_CLEAR;
            c_CLEAR:     w_next = c_FETCH_A;
            c_FETCH_A:   if (bus.mem_rd_valid && w_last) w_next = c_FETCH_B;
            c_FETCH_B:   if (bus.mem_rd_valid) w_next = c_PUSH_B;
            c_PUSH_B:    if (w_last) w_next = c_WAIT_DONE;
            c_WAIT_DONE: begin
                if (w_done_edge)               w_next = c_WRITEBACK;
                else if (r_tmo == c_TMO_LAST)  w_next = c_FINISH;
            end
            c_WRITEBACK: if (bus.mem_wr_ack && w_last) w_next = c_FINISH;
            c_FINISH:    w_next = c_IDLE;
            default:     w_next = c_IDLE;
        endcase
    end

    always_comb begin
        w_rd_req  = 1'b0;
        w_rd_addr = '0;
        w_a_load  = 1'b0;
        w_b_wren  = 1'b0;
        w_b_data  = '0;
        w_wr_req  = 1'b0;
        w_wr_addr = '0;
        w_wr_data = '0;
        case (r_state)
            c_FETCH_A: begin
                w_rd_req  = 1'b1;
                w_rd_addr = r_src + ADDR_WIDTH'(r_cnt);
                w_a_load  = bus.mem_rd_valid;
            end
            c_FETCH_B: begin
                w_rd_req  = 1'b1;
                w_rd_addr = r_src + ADDR_WIDTH'(4'd8);
            end
            c_PUSH_B: begin
                w_b_wren = 1'b1;
                w_b_data = r_bvec[r_cnt];
            end
            c_WRITEBACK: begin
                w_wr_req  = 1'b1;
                w_wr_addr = r_dst + ADDR_WIDTH'(r_cnt);
                w_wr_data = r_res[r_cnt];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src    <= '0;
            r_dst    <= '0;
            r_cnt    <= '0;
            r_tmo    <= '0;
            r_done_q <= 1'b0;
            r_error  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_bvec[i] <= '0;
                r_res[i]  <= '0;
            end
        end else begin
            r_done_q <= bus.mv_done;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_src   <= src_addr;
                        r_dst   <= dst_addr;
                        r_error <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                c_FETCH_A: begin
                    if (bus.mem_rd_valid) r_cnt <= r_cnt + 3'd1;
                end
                c_FETCH_B: begin
                    if (bus.mem_rd_valid) begin
                        for (int i = 0; i < 8; i++) begin
                            r_bvec[i] <= bus.mem_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                        r_cnt <= '0;
                    end
                end
                c_PUSH_B: begin
                    r_cnt <= r_cnt + 3'd1;
                    r_tmo <= '0;
                end
                c_WAIT_DONE: begin
                    r_tmo <= r_tmo + c_TMO_W'(1);
                    if (w_done_edge) begin
                        for (int i = 0; i < 8; i++) begin
                            r_res[i] <= bus.mv_out[i];
                        end
                        r_cnt <= '0;
                    end else if (r_tmo == c_TMO_LAST) begin
                        r_error <= 1'b1;
                    end
                end
                c_WRITEBACK: begin
                    if (bus.mem_wr_ack) r_cnt <= r_cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_a_lane
        assign bus.mv_a_data[gi] = w_a_load ? bus.mem_rd_data[gi*DATA_WIDTH +: DATA_WIDTH]
                                            : '0;
    end

    assign busy            = (r_state != c_IDLE);
    assign finished        = (r_state == c_FINISH);
    assign error           = r_error;
    assign bus.mv_clr      = (r_state == c_CLEAR);
    assign bus.mv_a_wren   = w_a_load;
    assign bus.mv_b_wren   = w_b_wren;
    assign bus.mv_b_data   = w_b_data;
    assign bus.mem_rd_req  = w_rd_req;
    assign bus.mem_rd_addr = w_rd_addr;
    assign bus.mem_wr_req  = w_wr_req;
    assign bus.mem_wr_addr = w_wr_addr;
    assign bus.mem_wr_data = w_wr_data;
endmodule
`default_nettype wire

// File: tb/tb_mat_vec_ctrl.sv
`default_nettype none
//============================================================================
// Module   : tb_mat_vec_ctrl
// Brief    : Bench for mat_vec_ctrl with memory responders and multiplier stub.
// Revision : 1.0
//============================================================================
module tb_mat_vec_ctrl;
    localparam int DW  = 8;
    localparam int AW  = 16;
    localparam int TMO = 16;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic          busy;
    logic          finished;
    logic          error;

    mat_vec_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mat_vec_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr),
        .dst_addr(dst_addr), .busy(busy), .finished(finished), .error(error),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    typedef struct {
        int kind;      // 0 identity, 1 all 0xFF, 2 random
        int rd_max;
        int wr_max;
        int stale;
        int drop_at;
        int rise_at;   // 0 = done never rises
        int poke;
        int exp_lat;   // -1 = not checked
        int exp_err;
    } job_t;

    logic [63:0] rmem [int];
    logic [23:0] wmem [int];
    int rd_max = 0, wr_max = 0, wr_acks = 0;
    int cfg_stale = 0, cfg_drop = 0, cfg_rise = 0;
    int n_clr = 0, n_a = 0, n_b = 0;

    // Read responder: random stall, spurious valid while no request.
    int          rd_wait = 0;
    bit          rd_stalled = 0;
    logic [AW-1:0] rd_last;
    always @(negedge clk) begin
        if (!rst_n) begin
            bus.mem_rd_valid = 1'b0; bus.mem_rd_data = '0; rd_wait = 0; rd_stalled = 0;
        end else begin
            if (rd_stalled) begin
                check("rd_req_held", bus.mem_rd_req, 1);
                if (bus.mem_rd_req) check("rd_addr_stable", bus.mem_rd_addr, rd_last);
            end
            if (!bus.mem_rd_req) begin
                rd_stalled = 0;
                bus.mem_rd_valid = 1'($urandom_range(0, 1));
                bus.mem_rd_data = {$urandom, $urandom};
                if (!busy) rd_wait = 0;
            end else if (rd_wait == 0) begin
                bus.mem_rd_valid = 1'b1;
                bus.mem_rd_data = rmem.exists(int'(bus.mem_rd_addr)) ? rmem[int'(bus.mem_rd_addr)] : 64'd0;
                rd_wait = $urandom_range(0, rd_max);
                rd_stalled = 0;
            end else begin
                bus.mem_rd_valid = 1'b0;
                rd_wait--;
                rd_stalled = 1;
                rd_last = bus.mem_rd_addr;
            end
        end
    end

    // Write responder: random stall, spurious ack while no request.
    int            wr_wait = 0;
    bit            wr_stalled = 0;
    logic [AW-1:0] wr_last_a;
    logic [23:0]   wr_last_d;
    always @(negedge clk) begin
        if (!rst_n) begin
            bus.mem_wr_ack = 1'b0; wr_wait = 0; wr_stalled = 0;
        end else begin
            if (wr_stalled) begin
                check("wr_req_held", bus.mem_wr_req, 1);
                if (bus.mem_wr_req) begin
                    check("wr_addr_stable", bus.mem_wr_addr, wr_last_a);
                    check("wr_data_stable", bus.mem_wr_data, wr_last_d);
                end
            end
            if (!bus.mem_wr_req) begin
                wr_stalled = 0;
                bus.mem_wr_ack = 1'($urandom_range(0, 1));
                if (!busy) wr_wait = 0;
            end else if (wr_wait == 0) begin
                bus.mem_wr_ack = 1'b1;
                wmem[int'(bus.mem_wr_addr)] = bus.mem_wr_data;
                wr_acks++;
                wr_wait = $urandom_range(0, wr_max);
                wr_stalled = 0;
            end else begin
                bus.mem_wr_ack = 1'b0;
                wr_wait--;
                wr_stalled = 1;
                wr_last_a = bus.mem_wr_addr;
                wr_last_d = bus.mem_wr_data;
            end
        end
    end

    // Multiplier stub: accumulates A*B from what the controller pushed.
    int amat [8][8];
    int bvec [8];
    int acc  [8];
    int a_idx = 0, b_idx = 0, t = 0;
    bit running = 0;
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin acc[i] = 0; bus.mv_out[i] = '0; end
            a_idx = 0; b_idx = 0; running = 0; t = 0; bus.mv_done = 1'b0;
        end else begin
            if (running) begin
                t++;
                if (t == cfg_drop) bus.mv_done = 1'b0;
                if (t == cfg_rise) begin
                    bus.mv_done = 1'b1;
                    for (int i = 0; i < 8; i++) bus.mv_out[i] = 24'(acc[i]);
                end
            end
            if (bus.mv_clr) begin
                for (int i = 0; i < 8; i++) acc[i] = 0;
                a_idx = 0; b_idx = 0; running = 0; n_clr++;
                if (cfg_stale == 0) bus.mv_done = 1'b0;
            end
            if (bus.mv_a_wren) begin
                for (int i = 0; i < 8; i++) amat[i][a_idx & 7] = int'(bus.mv_a_data[i]);
                a_idx++; n_a++;
            end
            if (bus.mv_b_wren) begin
                bvec[b_idx & 7] = int'(bus.mv_b_data);
                b_idx++; n_b++;
                if (b_idx == 8) begin
                    for (int i = 0; i < 8; i++)
                        for (int j = 0; j < 8; j++) acc[i] += amat[i][j] * bvec[j];
                    running = 1; t = 0;
                end
            end
        end
    end

    task automatic run_job(input job_t j, input int jn);
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [63:0]   col;
        logic [63:0]   vec;
        int cnt, got, clr0, a0, b0, w0;
        longint e, act;
        src = AW'($urandom_range(0, 16'h6000));
        dst = AW'(16'h8000 + jn * 16);
        for (int k = 0; k < 9; k++) begin
            case (j.kind)
                0:       rmem[int'(src + AW'(k))] = (k == 8) ? 64'h0807060504030201 : (64'h1 << (k * 8));
                1:       rmem[int'(src + AW'(k))] = 64'hFFFF_FFFF_FFFF_FFFF;
                default: rmem[int'(src + AW'(k))] = {$urandom, $urandom};
            endcase
        end
        rd_max = j.rd_max; wr_max = j.wr_max;
        cfg_stale = j.stale; cfg_drop = j.drop_at; cfg_rise = j.rise_at;
        clr0 = n_clr; a0 = n_a; b0 = n_b; w0 = wr_acks;
        src_addr = src; dst_addr = dst; start = 1'b1;
        cnt = 0; got = 0;
        while (cnt < 3000 && got == 0) begin
            @(posedge clk); cnt++;
            @(negedge clk);
            if (cnt == 1) begin
                start = 1'b0;
                check("busy_after_start", busy, 1);
                check("error_cleared", error, 0);
            end
            if (j.poke != 0 && cnt == 10) begin start = 1'b1; src_addr = ~src; dst_addr = ~dst; end
            if (j.poke != 0 && cnt == 11) start = 1'b0;
            if (finished) got = 1;
        end
        check("finished_seen", got, 1);
        if (j.exp_lat >= 0) check("latency", cnt, j.exp_lat);
        check("error_flag", error, j.exp_err);
        check("clr_pulses", n_clr - clr0, 1);
        check("a_wren_pulses", n_a - a0, 8);
        check("b_wren_pulses", n_b - b0, 8);
        check("write_count", wr_acks - w0, (j.exp_err != 0) ? 0 : 8);
        if (j.exp_err == 0) begin
            vec = rmem[int'(src + AW'(8))];
            for (int i = 0; i < 8; i++) begin
                e = 0;
                for (int k = 0; k < 8; k++) begin
                    col = rmem[int'(src + AW'(k))];
                    e += longint'(col[i*8 +: 8]) * longint'(vec[k*8 +: 8]);
                end
                act = wmem.exists(int'(dst + AW'(i))) ? longint'(wmem[int'(dst + AW'(i))]) : -1;
                check($sformatf("result_job%0d_%0d", jn, i), act, e);
            end
        end
        @(posedge clk); @(negedge clk);
        check("finished_one_cycle", finished, 0);
        check("idle_after_job", busy, 0);
        check("error_sticky", error, j.exp_err);
    endtask

    task automatic reset_mid_job();
        int saw;
        for (int k = 0; k < 9; k++) rmem[16'h0100 + k] = {$urandom, $urandom};
        cfg_stale = 0; cfg_drop = 0; cfg_rise = 3; rd_max = 0; wr_max = 0;
        src_addr = 16'h0100; dst_addr = 16'h7F00; start = 1'b1;
        @(posedge clk); @(negedge clk); start = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        check("mid_job_reading", bus.mem_rd_req, 1);
        rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_rd_req", bus.mem_rd_req, 0);
        check("rst_rd_addr", bus.mem_rd_addr, 0);
        check("rst_a_wren", bus.mv_a_wren, 0);
        check("rst_a_data0", bus.mv_a_data[0], 0);
        saw = 0;
        repeat (3) begin @(negedge clk); if (finished) saw = 1; end
        rst_n = 1'b1;
        repeat (4) begin @(negedge clk); if (finished || busy) saw = 1; end
        check("rst_no_finish_or_restart", saw, 0);
        check("rst_no_write", wmem.exists(16'h7F00) ? 1 : 0, 0);
    endtask

    job_t tbl [7];
    job_t rj;

    initial begin
        //          kind rd wr stale drop rise poke lat err
        tbl[0] = '{0,   0, 0, 0,    0,   4,   0,   31, 0};
        tbl[1] = '{1,   0, 0, 0,    0,   2,   0,   29, 0};
        tbl[2] = '{2,   0, 0, 1,    3,   6,   0,   33, 0};
        tbl[3] = '{2,   5, 5, 0,    0,   5,   0,   -1, 0};
        tbl[4] = '{2,   0, 0, 0,    0,   0,   0,   35, 1};
        tbl[5] = '{2,   0, 0, 0,    0,   1,   1,   28, 0};
        tbl[6] = '{2,   3, 2, 1,    2,   9,   0,   -1, 0};

        rst_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_finished", finished, 0);
        check("reset_error", error, 0);
        check("reset_rd_req", bus.mem_rd_req, 0);
        check("reset_wr_req", bus.mem_wr_req, 0);
        check("reset_clr", bus.mv_clr, 0);
        check("reset_b_wren", bus.mv_b_wren, 0);
        check("reset_wr_data", bus.mem_wr_data, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", busy, 0);

        for (int i = 0; i < 7; i++) run_job(tbl[i], i);
        reset_mid_job();

        for (int i = 0; i < 8; i++) begin
            rj.kind    = 2;
            rj.rd_max  = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 5);
            rj.wr_max  = (rj.rd_max == 0) ? 0 : $urandom_range(0, 5);
            rj.rise_at = $urandom_range(1, 14);
            rj.stale   = (rj.rise_at >= 3) ? $urandom_range(0, 1) : 0;
            rj.drop_at = (rj.stale != 0) ? $urandom_range(1, rj.rise_at - 1) : 0;
            rj.poke    = $urandom_range(0, 1);
            rj.exp_lat = (rj.rd_max == 0 && rj.wr_max == 0) ? 27 + rj.rise_at : -1;
            rj.exp_err = 0;
            run_job(rj, 10 + i);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
